perf_stats: RTL and testbench

Synthesizable performance-statistics unit that sits alongside the pipelined processor with caches. It consumes the per-cycle retire, I-cache and D-cache request/hit, and halt strobes produced by the fetch, decode and memory stages. It accumulates them in on-chip counters, freezes them when the processor halts, and returns any counter through a one-cycle read handshake. It gives software and the bench an in-design copy of the statistics the simulation harness prints at halt.

---
 rtl/perf_stats.sv | 158 +++++++++++++++
 tb/tb_perf_stats.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/perf_stats.sv
// Performance-statistics unit: cycle, retire and cache request/hit counters that freeze at halt.
// Optional build macro PERF_STATS_SAT_EN selects saturating counters; wrapping counters otherwise.
module perf_stats #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    input  logic             inst_retire,
    input  logic             icache_req,
    input  logic             icache_hit,
    input  logic             dcache_req,
    input  logic             dcache_hit,
    input  logic             halt,
    input  logic             rd_req,
    input  logic [2:0]       rd_sel,
    output logic             rd_valid,
    output logic [CNT_W-1:0] rd_data,
    output logic             frozen,
    output logic             running
);

    localparam int unsigned N_EV = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              frozen_nxt;
    logic              running_nxt;

    logic [CNT_W-1:0]  cnt     [N_EV];
    logic [CNT_W-1:0]  cnt_nxt [N_EV];
    logic [CNT_W-1:0]  halt_cyc;
    logic [N_EV-1:0]   status;
    logic [N_EV-1:0]   ovf;
    logic [N_EV-1:0]   inc;
    logic              counting;
    logic [CNT_W-1:0]  sel_val;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; clear beats start and halt
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!clear && start) state_nxt = RUN;
            RUN: begin
                if (clear && halt)    state_nxt = IDLE;
                else if (clear)       state_nxt = RUN;
                else if (halt)        state_nxt = FROZEN;
            end
            FROZEN:  if (clear) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from the next state so the registered flags track the state after each edge
    always_comb begin
        running_nxt = 1'b0;
        frozen_nxt  = 1'b0;
        case (state_nxt)
            RUN:     running_nxt = 1'b1;
            FROZEN:  frozen_nxt  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            running <= 1'b0;
            frozen  <= 1'b0;
        end else begin
            running <= running_nxt;
            frozen  <= frozen_nxt;
        end
    end

    // Per-counter increment enables; hits only count alongside their request
    always_comb begin
        counting = (state == RUN) && !clear;
        inc      = '0;
        if (counting) begin
            inc = {dcache_req & dcache_hit, dcache_req,
                   icache_req & icache_hit, icache_req,
                   inst_retire, 1'b1};
        end
    end

    // Counter update with overflow detection at all-ones
    always_comb begin
        ovf = '0;
        for (int i = 0; i < N_EV; i++) begin
            cnt_nxt[i] = cnt[i];
            if (inc[i]) begin
                if (cnt[i] == {CNT_W{1'b1}}) begin
                    ovf[i] = 1'b1;
`ifdef PERF_STATS_SAT_EN
                    cnt_nxt[i] = cnt[i];
`else
                    cnt_nxt[i] = '0;
`endif
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_EV; i++) cnt[i] <= '0;
            halt_cyc <= '0;
            status   <= '0;
        end else if (clear) begin
            for (int i = 0; i < N_EV; i++) cnt[i] <= '0;
            halt_cyc <= '0;
            status   <= '0;
        end else begin
            for (int i = 0; i < N_EV; i++) cnt[i] <= cnt_nxt[i];
            status <= status | ovf;
            if (state == RUN && halt) halt_cyc <= cnt_nxt[0];
        end
    end

    // Read mux sees pre-update values
    always_comb begin
        sel_val = '0;
        case (rd_sel)
            3'd6:    sel_val = halt_cyc;
            3'd7:    sel_val = CNT_W'(status);
            default: sel_val = cnt[rd_sel];
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_req;
            rd_data  <= rd_req ? sel_val : '0;
        end
    end

endmodule

// File: tb/tb_perf_stats.sv
// Directed bench for perf_stats: a 32-bit instance and a 4-bit instance share one stimulus stream.
module tb_perf_stats;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, clear, inst_retire, icache_req, icache_hit;
    logic        dcache_req, dcache_hit, halt, rd_req;
    logic [2:0]  rd_sel;
    logic        rd_valid, frozen, running;
    logic [31:0] rd_data;
    logic        s_rd_valid, s_frozen, s_running;
    logic [3:0]  s_rd_data;

    int cmp_cnt = 0;
    int err_cnt = 0;

`ifdef PERF_STATS_SAT_EN
    localparam logic [3:0] SMALL_CYC17 = 4'd15;
`else
    localparam logic [3:0] SMALL_CYC17 = 4'd1;
`endif

    always #5 clk = ~clk;

    perf_stats #(.CNT_W(32)) u_big (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .inst_retire(inst_retire), .icache_req(icache_req), .icache_hit(icache_hit),
        .dcache_req(dcache_req), .dcache_hit(dcache_hit), .halt(halt),
        .rd_req(rd_req), .rd_sel(rd_sel), .rd_valid(rd_valid), .rd_data(rd_data),
        .frozen(frozen), .running(running)
    );

    perf_stats #(.CNT_W(4)) u_small (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .inst_retire(inst_retire), .icache_req(icache_req), .icache_hit(icache_hit),
        .dcache_req(dcache_req), .dcache_hit(dcache_hit), .halt(halt),
        .rd_req(rd_req), .rd_sel(rd_sel), .rd_valid(s_rd_valid), .rd_data(s_rd_data),
        .frozen(s_frozen), .running(s_running)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [2:0] sel);
        rd_req = 1'b1;
        rd_sel = sel;
        step();
        rd_req = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; clear = 1'b0; inst_retire = 1'b0;
        icache_req = 1'b0; icache_hit = 1'b0; dcache_req = 1'b0; dcache_hit = 1'b0;
        halt = 1'b0; rd_req = 1'b0; rd_sel = 3'd0;
        step(); step();
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_rd_data", rd_data, 32'd0);
        check("reset_frozen", 32'(frozen), 32'd0);
        check("reset_running", 32'(running), 32'd0);
        rst = 1'b1;
        step();

        // Start, then 10 run cycles with 4 retires
        start = 1'b1; step(); start = 1'b0;
        check("start_running", 32'(running), 32'd1);
        check("start_frozen", 32'(frozen), 32'd0);
        for (int i = 1; i <= 10; i++) begin
            inst_retire = (i == 1 || i == 3 || i == 5 || i == 7);
            step();
        end
        inst_retire = 1'b0;
        rd(3'd0);
        check("a_sel0_valid", 32'(rd_valid), 32'd1);
        check("a_sel0_data", rd_data, 32'd10);
        check("a_small_sel0", 32'(s_rd_data), 32'd10);
        rd(3'd1);
        check("a_sel1_valid", 32'(rd_valid), 32'd1);
        check("a_sel1_data", rd_data, 32'd4);
        step();
        check("idle_rd_valid", 32'(rd_valid), 32'd0);
        check("idle_rd_data", rd_data, 32'd0);

        // Cache request/hit qualification
        for (int i = 0; i < 6; i++) begin
            icache_req = 1'b1;
            icache_hit = (i != 2);
            step();
        end
        icache_req = 1'b0; icache_hit = 1'b0;
        dcache_hit = 1'b1; step(); step(); dcache_hit = 1'b0;
        rd(3'd2); check("b_sel2", rd_data, 32'd6);
        rd(3'd3); check("b_sel3", rd_data, 32'd5);
        rd(3'd5); check("b_sel5", rd_data, 32'd0);
        rd(3'd4); check("b_sel4", rd_data, 32'd0);
        inst_retire = 1'b1; step(); step(); step(); inst_retire = 1'b0;

        // Clear with a simultaneous read returns the pre-clear value and stays in RUN
        clear = 1'b1; rd_req = 1'b1; rd_sel = 3'd1;
        step();
        clear = 1'b0; rd_req = 1'b0;
        check("c_clear_read", rd_data, 32'd7);
        check("c_clear_running", 32'(running), 32'd1);
        rd(3'd1);
        check("c_after_clear", rd_data, 32'd0);
        for (int i = 0; i < 16; i++) step();
        rd(3'd0);
        check("c_big_cyc17", rd_data, 32'd17);
        check("c_small_cyc17", 32'(s_rd_data), 32'(SMALL_CYC17));
        rd(3'd7);
        check("c_big_status", rd_data, 32'd0);
        check("c_small_status", 32'(s_rd_data), 32'd1);

        // Halt at run cycle 20 freezes everything
        clear = 1'b1; step(); clear = 1'b0;
        for (int i = 0; i < 19; i++) step();
        halt = 1'b1; inst_retire = 1'b1;
        step();
        halt = 1'b0;
        check("d_frozen", 32'(frozen), 32'd1);
        check("d_running", 32'(running), 32'd0);
        for (int i = 0; i < 50; i++) step();
        inst_retire = 1'b0;
        rd(3'd6); check("d_sel6", rd_data, 32'd20);
        rd(3'd0); check("d_sel0", rd_data, 32'd20);
        rd(3'd1); check("d_sel1", rd_data, 32'd1);
        check("d_still_frozen", 32'(frozen), 32'd1);

        // Clear from FROZEN, then clear+halt in RUN
        clear = 1'b1; step(); clear = 1'b0;
        check("e_frozen", 32'(frozen), 32'd0);
        check("e_running", 32'(running), 32'd0);
        rd(3'd0); check("e_sel0", rd_data, 32'd0);
        start = 1'b1; step(); start = 1'b0;
        check("e_restart", 32'(running), 32'd1);
        step(); step();
        clear = 1'b1; halt = 1'b1; step(); clear = 1'b0; halt = 1'b0;
        check("e_ch_frozen", 32'(frozen), 32'd0);
        check("e_ch_running", 32'(running), 32'd0);
        step(); step(); step();
        rd(3'd0); check("e_idle_sel0", rd_data, 32'd0);

        // Asynchronous reset while a read result is on the bus
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rd(3'd0);
        check("f_pre_valid", 32'(rd_valid), 32'd1);
        check("f_pre_data", rd_data, 32'd4);
        #3;
        rst = 1'b0;
        #1;
        check("f_rst_valid", 32'(rd_valid), 32'd0);
        check("f_rst_data", rd_data, 32'd0);
        check("f_rst_running", 32'(running), 32'd0);
        step();
        rst = 1'b1;
        step();
        rd(3'd0);
        check("f_post_valid", 32'(rd_valid), 32'd1);
        check("f_post_sel0", rd_data, 32'd0);
        rd(3'd7);
        check("f_post_status", rd_data, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
